// File: rtl/eif_tdm_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eif_tdm_scheduler_pkg
// Description : Shared definitions for the EIF time-multiplexed scheduler:
//               FSM state encodings, default reset membrane value and the
//               neuron-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package eif_tdm_scheduler_pkg;

    // Membrane value written at reset and after a spike.
    localparam int c_v_reset_default = 0;

    // Scheduler FSM encodings.
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_select = 3'd1;
    localparam logic [2:0] c_st_issue  = 3'd2;
    localparam logic [2:0] c_st_wait   = 3'd3;
    localparam logic [2:0] c_st_write  = 3'd4;

    // Width of a neuron index; never below one bit so vectors stay legal.
    function automatic int eif_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eif_tdm_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : eif_tdm_scheduler_if
// Description : Bundles the scheduler's datapath request/response bus and its
//               spike-event output stream.
//               master : scheduler side (drives dp_req/dp_state/dp_current,
//                        evt_valid/evt_id)
//               slave  : datapath + event consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface eif_tdm_scheduler_if #(
    parameter int STATE_W = 8,
    parameter int CUR_W   = 8,
    parameter int IDX_W   = 2
);
    // Datapath request / response
    logic               dp_req;
    logic [STATE_W-1:0] dp_state;
    logic [CUR_W-1:0]   dp_current;
    logic               dp_ack;
    logic [STATE_W-1:0] dp_state_nx;
    logic               dp_spike;

    // Spike event stream
    logic               evt_valid;
    logic [IDX_W-1:0]   evt_id;
    logic               evt_ready;

    modport master (
        output dp_req, dp_state, dp_current, evt_valid, evt_id,
        input  dp_ack, dp_state_nx, dp_spike, evt_ready
    );

    modport slave (
        input  dp_req, dp_state, dp_current, evt_valid, evt_id,
        output dp_ack, dp_state_nx, dp_spike, evt_ready
    );

endinterface
`default_nettype wire

// File: rtl/eif_tdm_scheduler_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : eif_tdm_scheduler_evt_fifo
// Description : Small synchronous FIFO holding spiking neuron indices.
//               Ports: i_push/i_din write side, i_pop read side (ignored when
//               empty), o_dout head value (0 when empty), o_empty, and
//               o_overflow, a same-cycle flag for a push that was dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module eif_tdm_scheduler_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_dout,
    output logic                  o_empty,
    output logic                  o_overflow
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_overflow = i_push && !w_do_push;

    assign o_dout = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eif_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : eif_tdm_scheduler
// Description : Time-multiplexes one shared EIF update datapath across
//               N_NEURONS virtual neurons. Holds per-neuron membrane state and
//               refractory counters, sweeps neurons 0..N-1 on each tick and
//               queues spiking neuron indices in an event FIFO.
//               Ports: clk/rst, tick (start sweep), cur_in (packed currents),
//               refrac_cfg, en_mask, bus (datapath + event interface),
//               busy, sweep_done, overrun (sticky), mon_state (neuron 0).
// Revision    : 1.0 - initial release
// ============================================================================
module eif_tdm_scheduler
    import eif_tdm_scheduler_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int STATE_W   = 8,
    parameter int CUR_W     = 8,
    parameter int REFRAC_W  = 4,
    parameter int V_RESET   = c_v_reset_default,
    parameter int EVT_DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       tick,
    input  wire logic [N_NEURONS*CUR_W-1:0] cur_in,
    input  wire logic [REFRAC_W-1:0]        refrac_cfg,
    input  wire logic [N_NEURONS-1:0]       en_mask,
    eif_tdm_scheduler_if.master             bus,
    output logic                            busy,
    output logic                            sweep_done,
    output logic                            overrun,
    output logic      [STATE_W-1:0]         mon_state
);

    localparam int                 IDX_W      = eif_idx_w(N_NEURONS);
    localparam logic [STATE_W-1:0] c_v_reset  = STATE_W'(V_RESET);
    localparam logic [IDX_W-1:0]   c_last_idx = IDX_W'(N_NEURONS - 1);

    // Registered state
    logic [2:0]          r_fsm;
    logic [IDX_W-1:0]    r_idx;
    logic [STATE_W-1:0]  r_state  [N_NEURONS];
    logic [REFRAC_W-1:0] r_refrac [N_NEURONS];
    logic [CUR_W-1:0]    r_cur;
    logic                r_dp_req;
    logic [STATE_W-1:0]  r_nx;
    logic                r_spike;
    logic                r_busy;
    logic                r_sweep_done;
    logic                r_overrun;
    logic [STATE_W-1:0]  r_mon_state;

    // Combinational decode
    logic             w_skip_dis;
    logic             w_skip_refrac;
    logic             w_issue;
    logic             w_advance;
    logic             w_push;
    logic [CUR_W-1:0] w_cur_sel;
    logic [IDX_W-1:0] w_evt_id;
    logic             w_fifo_empty;
    logic             w_fifo_overflow;

    assign w_cur_sel = cur_in[r_idx*CUR_W +: CUR_W];

    // SELECT resolves to exactly one of: skip (disabled), skip (refractory)
    // or issue. Disabled takes priority so a masked neuron's refractory
    // counter is frozen along with its state.
    always_comb begin
        w_skip_dis    = 1'b0;
        w_skip_refrac = 1'b0;
        w_issue       = 1'b0;
        if (r_fsm == c_st_select) begin
            if (!en_mask[r_idx]) begin
                w_skip_dis = 1'b1;
            end else if (r_refrac[r_idx] != '0) begin
                w_skip_refrac = 1'b1;
            end else begin
                w_issue = 1'b1;
            end
        end
    end

    assign w_advance = w_skip_dis || w_skip_refrac || (r_fsm == c_st_write);
    assign w_push    = (r_fsm == c_st_write) && r_spike;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm        <= c_st_idle;
            r_idx        <= '0;
            r_cur        <= '0;
            r_dp_req     <= 1'b0;
            r_nx         <= '0;
            r_spike      <= 1'b0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_overrun    <= 1'b0;
            r_mon_state  <= c_v_reset;
        end else begin
            r_sweep_done <= 1'b0;
            r_mon_state  <= r_state[0];

            if ((tick && r_busy) || w_fifo_overflow) begin
                r_overrun <= 1'b1;
            end

            case (r_fsm)
                c_st_idle: begin
                    if (tick) begin
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        r_fsm  <= c_st_select;
                    end
                end
                c_st_select: begin
                    if (w_issue) begin
                        r_cur    <= w_cur_sel;
                        r_dp_req <= 1'b1;
                        r_fsm    <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_fsm <= c_st_wait;
                end
                c_st_wait: begin
                    // Acks seen in any other state are ignored.
                    if (bus.dp_ack) begin
                        r_nx     <= bus.dp_state_nx;
                        r_spike  <= bus.dp_spike;
                        r_dp_req <= 1'b0;
                        r_fsm    <= c_st_write;
                    end
                end
                c_st_write: begin
                    r_fsm <= c_st_write;
                end
                default: begin
                    r_fsm    <= c_st_idle;
                    r_busy   <= 1'b0;
                    r_dp_req <= 1'b0;
                end
            endcase

            // Skips and writes both move on to the next neuron; the last
            // neuron closes the sweep.
            if (w_advance) begin
                if (r_idx == c_last_idx) begin
                    r_fsm        <= c_st_idle;
                    r_busy       <= 1'b0;
                    r_sweep_done <= 1'b1;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_fsm <= c_st_select;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-neuron membrane and refractory storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                r_state[i]  <= c_v_reset;
                r_refrac[i] <= '0;
            end
        end else if (w_skip_refrac) begin
            r_refrac[r_idx] <= r_refrac[r_idx] - 1'b1;
            r_state[r_idx]  <= c_v_reset;
        end else if (r_fsm == c_st_write) begin
            if (r_spike) begin
                r_state[r_idx]  <= c_v_reset;
                r_refrac[r_idx] <= refrac_cfg;
            end else begin
                r_state[r_idx] <= r_nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Spike event FIFO
    // ------------------------------------------------------------------
    eif_tdm_scheduler_evt_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_din      (r_idx),
        .i_pop      (bus.evt_ready),
        .o_dout     (w_evt_id),
        .o_empty    (w_fifo_empty),
        .o_overflow (w_fifo_overflow)
    );

    // Outputs
    assign bus.dp_req     = r_dp_req;
    assign bus.dp_state   = r_state[r_idx];
    assign bus.dp_current = r_cur;
    assign bus.evt_valid  = !w_fifo_empty;
    assign bus.evt_id     = w_evt_id;
    assign busy           = r_busy;
    assign sweep_done     = r_sweep_done;
    assign overrun        = r_overrun;
    assign mon_state      = r_mon_state;

endmodule
`default_nettype wire

// File: tb/tb_eif_tdm_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_eif_tdm_scheduler
// Description : Self-checking bench for eif_tdm_scheduler. A behavioural
//               datapath answers requests with state+current and raises spikes
//               on selected currents; each sweep is described by one table
//               record with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eif_tdm_scheduler;

    localparam int N  = 4;
    localparam int SW = 8;
    localparam int CW = 8;
    localparam int RW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            tick;
    logic [N*CW-1:0] cur_in;
    logic [RW-1:0]   refrac_cfg;
    logic [N-1:0]    en_mask;
    logic            busy;
    logic            sweep_done;
    logic            overrun;
    logic [SW-1:0]   mon_state;

    // Datapath model controls
    logic            ack_hold;
    logic            spike_all;
    logic            spike_en;
    logic [CW-1:0]   spike_cur;

    int n_checks = 0;
    int n_fail   = 0;

    eif_tdm_scheduler_if #(.STATE_W(SW), .CUR_W(CW), .IDX_W(IW)) bus ();

    eif_tdm_scheduler #(
        .N_NEURONS (N),
        .STATE_W   (SW),
        .CUR_W     (CW),
        .REFRAC_W  (RW),
        .V_RESET   (0),
        .EVT_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .cur_in     (cur_in),
        .refrac_cfg (refrac_cfg),
        .en_mask    (en_mask),
        .bus        (bus),
        .busy       (busy),
        .sweep_done (sweep_done),
        .overrun    (overrun),
        .mon_state  (mon_state)
    );

    always #5 clk = ~clk;

    // Datapath: acknowledges immediately unless held, next = state + current.
    always_comb begin
        bus.dp_ack      = bus.dp_req && !ack_hold;
        bus.dp_state_nx = bus.dp_state + bus.dp_current;
        bus.dp_spike    = spike_all || (spike_en && (bus.dp_current == spike_cur));
    end

    // Record {state, current} at each new request.
    logic [15:0] log_q [$];
    logic        prev_req = 1'b0;
    always @(negedge clk) begin
        if (bus.dp_req && !prev_req) begin
            log_q.push_back({bus.dp_state, bus.dp_current});
        end
        prev_req <= bus.dp_req;
    end

    typedef struct {
        logic [31:0] cur;
        logic [3:0]  en;
        logic [3:0]  refrac;
        logic        spike_all;
        logic        spike_en;
        logic [7:0]  spike_cur;
        int          exp_cycles;
        int          exp_issues;
        logic [31:0] exp_states;   // issue order, byte 0 = first issue
        logic [31:0] exp_curs;
        logic [7:0]  exp_mon;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int          cyc;
        logic [31:0] gs;
        logic [31:0] gc;
        cur_in     = v.cur;
        en_mask    = v.en;
        refrac_cfg = v.refrac;
        spike_all  = v.spike_all;
        spike_en   = v.spike_en;
        spike_cur  = v.spike_cur;
        @(negedge clk);
        log_q.delete();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        cyc  = 0;
        while (!sweep_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_cycles", tag), cyc, v.exp_cycles);
        check($sformatf("%s_issues", tag), log_q.size(), v.exp_issues);
        gs = '0;
        gc = '0;
        for (int k = 0; k < log_q.size() && k < 4; k++) begin
            gs[k*8 +: 8] = log_q[k][15:8];
            gc[k*8 +: 8] = log_q[k][7:0];
        end
        check($sformatf("%s_states", tag), gs, v.exp_states);
        check($sformatf("%s_curs", tag), gc, v.exp_curs);
        @(negedge clk);
        @(negedge clk);
        check($sformatf("%s_mon", tag), mon_state, v.exp_mon);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tick = 1'b0; cur_in = '0; en_mask = 4'hf; refrac_cfg = '0;
        bus.evt_ready = 1'b0; ack_hold = 1'b0; spike_all = 1'b0; spike_en = 1'b0; spike_cur = '0;

        // Sweeps 0-1: all currents 1, no spikes -> states step 0->1->2.
        vecs[0] = '{cur:32'h01010101, en:4'hf, refrac:4'd0, spike_all:0, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h00000000, exp_curs:32'h01010101, exp_mon:8'd1};
        vecs[1] = '{cur:32'h01010101, en:4'hf, refrac:4'd0, spike_all:0, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h01010101, exp_curs:32'h01010101, exp_mon:8'd2};
        // Sweep 2: currents 1,2,3,4; neuron 2 (current 3) spikes, refractory 2.
        vecs[2] = '{cur:32'h04030201, en:4'hf, refrac:4'd2, spike_all:0, spike_en:1, spike_cur:8'd3,
                    exp_cycles:16, exp_issues:4, exp_states:32'h02020202, exp_curs:32'h04030201, exp_mon:8'd3};
        // Sweeps 3-4: neuron 2 refractory -> skipped (one cycle each).
        vecs[3] = '{cur:32'h04030201, en:4'hf, refrac:4'd2, spike_all:0, spike_en:1, spike_cur:8'd3,
                    exp_cycles:13, exp_issues:3, exp_states:32'h00060403, exp_curs:32'h00040201, exp_mon:8'd4};
        vecs[4] = '{cur:32'h04030201, en:4'hf, refrac:4'd2, spike_all:0, spike_en:1, spike_cur:8'd3,
                    exp_cycles:13, exp_issues:3, exp_states:32'h000A0604, exp_curs:32'h00040201, exp_mon:8'd5};
        // Sweep 5: only neurons 0 and 2 enabled.
        vecs[5] = '{cur:32'h04030201, en:4'b0101, refrac:4'd0, spike_all:0, spike_en:0, spike_cur:8'd0,
                    exp_cycles:10, exp_issues:2, exp_states:32'h00000005, exp_curs:32'h00000301, exp_mon:8'd6};
        // Sweep 6: all enabled again; neurons 1 and 3 held 8 and 14.
        vecs[6] = '{cur:32'h01010101, en:4'hf, refrac:4'd0, spike_all:0, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h0E030806, exp_curs:32'h01010101, exp_mon:8'd7};
        // Sweeps 7-8: every neuron spikes, no consumer, refractory 0.
        vecs[7] = '{cur:32'h01010101, en:4'hf, refrac:4'd0, spike_all:1, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h0F040907, exp_curs:32'h01010101, exp_mon:8'd0};
        vecs[8] = '{cur:32'h01010101, en:4'hf, refrac:4'd0, spike_all:1, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h00000000, exp_curs:32'h01010101, exp_mon:8'd0};
        // Sweep 9: restart after a mid-sweep reset.
        vecs[9] = '{cur:32'h04030201, en:4'hf, refrac:4'd0, spike_all:0, spike_en:0, spike_cur:8'd0,
                    exp_cycles:16, exp_issues:4, exp_states:32'h00000000, exp_curs:32'h04030201, exp_mon:8'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_dp_req", bus.dp_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sweep_done", sweep_done, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_evt_valid", bus.evt_valid, 1'b0);
        check("rst_evt_id", bus.evt_id, 2'd0);
        check("rst_mon_state", mon_state, 8'd0);

        for (int i = 0; i < 7; i++) begin
            apply_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Only neuron 2's spike from sweep 2 is queued.
        check("evt_single_valid", bus.evt_valid, 1'b1);
        check("evt_single_id", bus.evt_id, 2'd2);
        check("evt_single_overrun", overrun, 1'b0);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        check("evt_single_popped", bus.evt_valid, 1'b0);

        // Fill the FIFO exactly, then overflow it.
        apply_vec(vecs[7], "fill");
        check("fill_overrun", overrun, 1'b0);
        check("fill_evt_valid", bus.evt_valid, 1'b1);
        apply_vec(vecs[8], "ovf");
        check("ovf_overrun", overrun, 1'b1);
        bus.evt_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pop%0d_valid", k), bus.evt_valid, 1'b1);
            check($sformatf("pop%0d_id", k), bus.evt_id, k[1:0]);
            @(negedge clk);
        end
        bus.evt_ready = 1'b0;
        check("pop_empty", bus.evt_valid, 1'b0);
        check("ovf_overrun_sticky", overrun, 1'b1);

        pulse_rst();
        check("rst2_overrun", overrun, 1'b0);
        check("rst2_evt_valid", bus.evt_valid, 1'b0);

        // Tick while busy is ignored and flags overrun.
        spike_all = 1'b0; spike_en = 1'b0; en_mask = 4'hf;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        check("tick_busy_overrun", overrun, 1'b1);
        check("tick_busy_busy", busy, 1'b1);
        begin
            int w = 0;
            while (busy && w < 40) begin
                @(negedge clk);
                w++;
            end
            check("tick_busy_sweep_ends", busy, 1'b0);
        end
        repeat (20) @(negedge clk);
        check("tick_busy_no_restart", busy, 1'b0);
        check("tick_busy_overrun_sticky", overrun, 1'b1);

        // Reset during WAIT with the ack withheld.
        pulse_rst();
        check("rst3_overrun", overrun, 1'b0);
        ack_hold = 1'b1;
        @(negedge clk); tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        repeat (6) @(negedge clk);
        check("wait_dp_req", bus.dp_req, 1'b1);
        check("wait_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_dp_req", bus.dp_req, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        ack_hold = 1'b0;
        apply_vec(vecs[9], "restart");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
